// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//
// Owns the architectural PC of the single-cycle core and runs the
// instruction-memory fetch handshake. It issues one fetch per instruction and
// holds the fetched word until execute accepts it. On that handshake it moves
// the PC to next_pc. A misaligned next_pc or a memory that never acknowledges
// raises a sticky fault, and only reset clears it.
//
// Parameters:
//   RESET_PC     PC loaded on reset (bits [1:0] must be zero)
//   MAX_WAIT     REQ cycles without ack before a timeout fault (1..255)
//
// Ports:
//   clk          core clock
//   rst_n        asynchronous active-low reset
//   next_pc      next PC from the next-PC adder, sampled on the handshake
//   pc           current PC register
//   imem_req     fetch request (registered)
//   imem_addr    fetch address, a direct copy of pc
//   imem_ack     memory returns imem_rdata this cycle
//   imem_rdata   instruction word
//   instr        fetched instruction, held until accepted
//   instr_valid  instr is valid
//   instr_ready  execute accepts instr this cycle
//   fetch_fault  sticky fault flag
//   fault_cause  01 misaligned next_pc, 10 imem timeout, 00 none
//
// Optional feature (macro FETCH_PERF_COUNTERS_EN):
//   fetch_count  number of accepted instructions
//   stall_count  REQ cycles without ack plus VALID cycles without ready

module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] next_pc,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        fetch_fault,
  output logic [1:0]  fault_cause
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2,
    FAULT = 2'd3
  } state_e;

  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [7:0]  WAIT_LIMIT = 8'(MAX_WAIT - 1);
  localparam logic [1:0]  CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0]  CAUSE_TIMEOUT  = 2'b10;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [7:0]  wait_q, wait_d;
  logic [1:0]  cause_q, cause_d;
  logic        req_q, req_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;

  // Next-state logic. The wait counter is checked before it increments, so
  // with MAX_WAIT=N the fault is taken at the end of the N-th REQ cycle
  // without ack. An ack in that same cycle still wins.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    wait_d  = wait_q;
    cause_d = cause_q;

    case (state_q)
      BOOT: begin
        wait_d  = 8'd0;
        state_d = REQ;
      end
      REQ: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          wait_d  = 8'd0;
          state_d = VALID;
        end else if (wait_q == WAIT_LIMIT) begin
          cause_d = CAUSE_TIMEOUT;
          state_d = FAULT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      VALID: begin
        if (instr_ready) begin
          if (next_pc[1:0] == 2'b00) begin
            pc_d    = next_pc;
            state_d = REQ;
          end else begin
            cause_d = CAUSE_MISALIGN;
            state_d = FAULT;
          end
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = BOOT;
      end
    endcase

    // The status outputs are decoded from the next state so they come
    // straight out of flops aligned with state_q.
    req_d   = (state_d == REQ);
    valid_d = (state_d == VALID);
    fault_d = (state_d == FAULT);
  end

  // State and output registers. Reset abandons any fetch in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= NOP;
      wait_q  <= 8'd0;
      cause_q <= 2'b00;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign imem_req    = req_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign fetch_fault = fault_q;
  assign fault_cause = cause_q;

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // The counters only move in REQ and VALID, so they freeze on their own
  // once FAULT is entered.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (state_q == VALID && instr_ready) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
    if ((state_q == REQ && !imem_ack) || (state_q == VALID && !instr_ready)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer, built with RESET_PC=8000_0000 and
// MAX_WAIT=4. The memory returns the inverted address as its data word, so
// the bench can compute every expected instruction from the expected PC.

module tb_fetch_sequencer;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] nextPcWire;
  logic [31:0] pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        ackWire;
  logic [31:0] rdataWire;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        fetch_fault;
  logic [1:0]  fault_cause;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] fetchCount;
  logic [31:0] stallCount;
`endif

  logic        autoAck = 1'b0;
  logic        ackDrive = 1'b0;
  logic        useOverride = 1'b0;
  logic [31:0] npOverride = 32'h0;

  int checkCount = 0;
  int errorCount = 0;

  // The memory answers with ~address. The ack can follow the request in the
  // same cycle or be driven by hand. next_pc is pc+4 unless overridden.
  assign ackWire    = autoAck ? imem_req : ackDrive;
  assign rdataWire  = ~imem_addr;
  assign nextPcWire = useOverride ? npOverride : pc + 32'd4;

  fetch_sequencer #(.RESET_PC(RST_PC), .MAX_WAIT(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .next_pc     (nextPcWire),
    .pc          (pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (ackWire),
    .imem_rdata  (rdataWire),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .fetch_fault (fetch_fault),
    .fault_cause (fault_cause)
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    .fetch_count (fetchCount),
    .stall_count (stallCount)
`endif
  );

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Assert reset for two cycles and release it on a falling edge. The cycle
  // that follows the release is the BOOT cycle.
  task automatic applyStimulus();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Same-cycle ack, always ready, sequential PCs.
    autoAck = 1'b1;
    instr_ready = 1'b1;
    applyStimulus();
    checkOutput("boot_pc", pc, RST_PC);
    checkOutput("boot_req", 32'(imem_req), 32'd0);
    checkOutput("boot_instr", instr, NOP);
    checkOutput("boot_valid", 32'(instr_valid), 32'd0);
    checkOutput("boot_fault", 32'(fetch_fault), 32'd0);
    checkOutput("boot_cause", 32'(fault_cause), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("seq_req", 32'(imem_req), 32'd1);
      checkOutput("seq_addr", imem_addr, RST_PC + 32'(4 * i));
      checkOutput("seq_valid_lo", 32'(instr_valid), 32'd0);
      @(negedge clk);
      checkOutput("seq_valid_hi", 32'(instr_valid), 32'd1);
      checkOutput("seq_instr", instr, ~(RST_PC + 32'(4 * i)));
    end

    // Execute stalls for five cycles in VALID and accepts on the sixth.
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall_valid", 32'(instr_valid), 32'd1);
      checkOutput("stall_instr", instr, ~(RST_PC + 32'd8));
      checkOutput("stall_pc", pc, RST_PC + 32'd8);
      checkOutput("stall_req", 32'(imem_req), 32'd0);
    end
    instr_ready = 1'b1;
    @(negedge clk);
    checkOutput("resume_pc", pc, RST_PC + 32'd12);
    checkOutput("resume_req", 32'(imem_req), 32'd1);

    // A misaligned next_pc at the handshake faults and keeps the old PC.
    @(negedge clk);
    checkOutput("pre_mis_valid", 32'(instr_valid), 32'd1);
    useOverride = 1'b1;
    npOverride = 32'h0000_0102;
    @(negedge clk);
    checkOutput("mis_fault", 32'(fetch_fault), 32'd1);
    checkOutput("mis_cause", 32'(fault_cause), 32'd1);
    checkOutput("mis_pc", pc, RST_PC + 32'd12);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("mis_hold_req", 32'(imem_req), 32'd0);
      checkOutput("mis_hold_fault", 32'(fetch_fault), 32'd1);
    end
    useOverride = 1'b0;

    // No ack ever: the fault is taken after the fourth REQ cycle.
    autoAck = 1'b0;
    ackDrive = 1'b0;
    applyStimulus();
    checkOutput("rst_clears_fault", 32'(fetch_fault), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("to_req", 32'(imem_req), 32'd1);
      checkOutput("to_nofault", 32'(fetch_fault), 32'd0);
    end
    @(negedge clk);
    checkOutput("to_fault", 32'(fetch_fault), 32'd1);
    checkOutput("to_cause", 32'(fault_cause), 32'd2);
    checkOutput("to_req_off", 32'(imem_req), 32'd0);

    // An ack on the fourth REQ cycle wins over the timeout.
    applyStimulus();
    repeat (3) @(negedge clk);
    checkOutput("late_req", 32'(imem_req), 32'd1);
    @(negedge clk);
    ackDrive = 1'b1;
    @(negedge clk);
    ackDrive = 1'b0;
    checkOutput("late_fault", 32'(fetch_fault), 32'd0);
    checkOutput("late_valid", 32'(instr_valid), 32'd1);
    checkOutput("late_instr", instr, ~RST_PC);

    // Reset mid-REQ, with a stray ack in the BOOT cycle after release.
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    checkOutput("mid_addr", imem_addr, RST_PC + 32'd4);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_pc", pc, RST_PC);
    checkOutput("mid_rst_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ackDrive = 1'b1;
    @(negedge clk);
    ackDrive = 1'b0;
    checkOutput("boot_ack_valid", 32'(instr_valid), 32'd0);
    checkOutput("boot_ack_req", 32'(imem_req), 32'd1);
    checkOutput("boot_ack_addr", imem_addr, RST_PC);
    @(negedge clk);
    checkOutput("restart_wait", 32'(instr_valid), 32'd0);
    ackDrive = 1'b1;
    @(negedge clk);
    ackDrive = 1'b0;
    checkOutput("restart_valid", 32'(instr_valid), 32'd1);
    checkOutput("restart_instr", instr, ~RST_PC);

`ifdef FETCH_PERF_COUNTERS_EN
    // Three instructions, each with one ack-wait and two ready-wait cycles.
    applyStimulus();
    checkOutput("perf_rst_fetch", fetchCount, 32'd0);
    checkOutput("perf_rst_stall", stallCount, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      instr_ready = 1'b0;
      ackDrive = 1'b0;
      @(negedge clk);
      ackDrive = 1'b1;
      @(negedge clk);
      ackDrive = 1'b0;
      @(negedge clk);
      @(negedge clk);
      instr_ready = 1'b1;
    end
    @(negedge clk);
    instr_ready = 1'b0;
    checkOutput("perf_fetch", fetchCount, 32'd3);
    checkOutput("perf_stall", stallCount, 32'd9);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Owns the architectural PC register and the instruction-memory fetch handshake for the single-cycle core.
- Exposes the current `pc` to the next-PC adder and consumes its `next_pc` result.
- Issues one fetch per instruction and holds the fetched word until the execute stage accepts it, then advances `pc` to `next_pc`.
- Detects misaligned targets and memory timeouts; either condition raises a sticky fault.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- MAX_WAIT, 16, number of REQ cycles without ack before a timeout fault; range 1..255.

Ports:
- clk  input  1  core clock
- rst_n  input  1  reset, asynchronous, active-low
- next_pc  input  32  next PC from the next-PC adder, computed from `pc`
- pc  output  32  current PC; feeds the next-PC adder
- imem_req  output  1  fetch request
- imem_addr  output  32  fetch address; equals `pc`
- imem_ack  input  1  memory has returned data this cycle
- imem_rdata  input  32  instruction word; valid when imem_ack=1
- instr  output  32  fetched instruction to decode/execute
- instr_valid  output  1  instr is valid
- instr_ready  input  1  execute accepts instr; next_pc is valid this cycle
- fetch_fault  output  1  sticky fault flag
- fault_cause  output  2  01 = misaligned next_pc, 10 = imem timeout, 00 = none

Behaviour:
- Reset is asynchronous, active-low, and forces all state immediately:
  - pc=RESET_PC, state=BOOT, imem_req=0, instr=32'h0000_0013 (NOP), instr_valid=0.
  - fetch_fault=0, fault_cause=00, wait counter=0.
- Reset mid-transaction abandons the request. An imem_ack arriving after reset release while in BOOT is ignored.
- States and transitions:
  - BOOT: imem_req=0. Moves to REQ unconditionally on the next cycle, giving one idle cycle after reset release.
  - REQ:
    - Outputs: imem_req=1, imem_addr=pc; addr stays stable while req is high.
    - On imem_ack=1: latch imem_rdata into instr, clear the counter, go to VALID.
    - Otherwise: increment the counter. If the counter reaches MAX_WAIT-1 with no ack, go to FAULT with cause 10.
    - An ack in the same cycle as the limit wins (no fault).
  - VALID:
    - Outputs: imem_req=0, instr_valid=1; instr is held stable.
    - On instr_ready=1 with next_pc[1:0]==0: pc<=next_pc, go to REQ.
    - On instr_ready=1 with next_pc[1:0]!=0: pc is unchanged, go to FAULT with cause 01.
    - With instr_ready=0: hold indefinitely; pc is unchanged.
  - FAULT:
    - Outputs: imem_req=0, instr_valid=0, fetch_fault=1; fault_cause is held.
    - Exits only through rst_n.
- Latency and throughput:
  - Minimum 2 cycles per instruction: REQ with same-cycle ack, then VALID with instr_ready=1.
  - First instr_valid appears no earlier than cycle 3 after reset release.
- pc changes only on a VALID&&instr_ready handshake. `next_pc` is sampled only in that cycle.
- imem_ack outside REQ is ignored.
- All arithmetic is 32-bit. pc wrap-around is the next-PC adder's concern; this block stores the value as given.
- Outputs are registered except imem_addr, which is a direct copy of the pc register.

Optional Feature:
- Macro: FETCH_PERF_COUNTERS_EN.
- Defined:
  - Adds output `fetch_count` [31:0]: increments on each VALID&&instr_ready handshake.
  - Adds output `stall_count` [31:0]: increments on every cycle in REQ without ack, and every cycle in VALID without instr_ready.
  - Both counters reset to 0, wrap at 2^32, and freeze in FAULT.
- Undefined: neither port nor the counters exist; behaviour is otherwise identical.

Test Plan:
- Reset with RESET_PC=32'h8000_0000, imem_ack tied to imem_req, instr_ready=1, next_pc=pc+4 → imem_addr sequence 8000_0000, 8000_0004, 8000_0008; instr_valid every 2nd cycle; first valid at cycle 3 after release.
- instr_ready held 0 for 5 cycles in VALID → instr and pc unchanged, imem_req=0. Ready on cycle 6 → pc=next_pc, REQ next cycle.
- next_pc=32'h0000_0102 at handshake → fetch_fault=1, fault_cause=01, pc keeps old value, imem_req stays 0 until rst_n pulse.
- MAX_WAIT=4, imem_ack never asserted → FAULT entered after 4 REQ cycles, cause 10. Repeat with ack on the 4th cycle → no fault, instr latched.
- rst_n asserted mid-REQ with ack arriving 1 cycle after release → ack ignored in BOOT, pc=RESET_PC, fetch restarts cleanly.
- With FETCH_PERF_COUNTERS_EN: 3 instructions, each with 1 ack-wait and 2 ready-wait cycles → fetch_count=3, stall_count=9.
